soft_fifo_flags: RTL and testbench

- Parametrised successor to the team's register-based (non-block-RAM) simulation FIFO.
- Adds:
  - selectable read mode (show-ahead or registered output)
  - occupancy count output
  - almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags with a clear input
- Used wherever a simulation-safe FIFO needs flow-control headroom or protocol-error visibility.
- The accelerator/host glue instantiates it in place of vendor FIFOs.

---
 rtl/soft_fifo_pkg.sv | 23 ++
 rtl/soft_fifo_ctrl.sv | 101 ++++++++++
 rtl/soft_fifo_flags.sv | 83 ++++++++
 tb/tb_soft_fifo_flags.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/soft_fifo_pkg.sv
// Shared types and parameter helpers for the soft FIFO family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package soft_fifo_pkg;

  // Supported range for log2 of the slot count.
  localparam int LOG_DEPTH_MIN = 1;
  localparam int LOG_DEPTH_MAX = 12;

  // Sticky protocol-error flags kept together so they are set/cleared as a unit.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  // Clamp a threshold into [lo, hi]; a parameter is legal iff clamping leaves it unchanged.
  function automatic int clamp_thresh(input int val, input int lo, input int hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

endpackage

// File: rtl/soft_fifo_ctrl.sv
// Pointer/occupancy controller: accept logic, usedw, threshold decodes, sticky errors.
// Latency: state updates on the clock edge after an accepted op; flags decode from registered usedw.
// Backpressure: writes dropped while full, reads ignored while empty; both recorded as sticky errors.
module soft_fifo_ctrl
  import soft_fifo_pkg::*;
#(
  parameter int LOG_DEPTH = 9,
  parameter int AF_THRESH = (1 << LOG_DEPTH) - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wrreq,
  input  logic                 rdreq,
  input  logic                 err_clr,
  output logic                 wr_acc,
  output logic [LOG_DEPTH-1:0] wr_ptr,
  output logic [LOG_DEPTH-1:0] rd_ptr,
  output logic [LOG_DEPTH:0]   usedw,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0]   DEPTH_U = DEPTH[LOG_DEPTH:0];
  localparam logic [LOG_DEPTH:0]   AF_U    = AF_THRESH[LOG_DEPTH:0];
  localparam logic [LOG_DEPTH:0]   AE_U    = AE_THRESH[LOG_DEPTH:0];
  localparam logic [LOG_DEPTH-1:0] PTR_ONE = {{(LOG_DEPTH-1){1'b0}}, 1'b1};
  localparam logic [LOG_DEPTH:0]   CNT_ONE = {{LOG_DEPTH{1'b0}}, 1'b1};

  // Reject out-of-range thresholds and depths at elaboration.
  if (AF_THRESH != clamp_thresh(AF_THRESH, 1, DEPTH)) begin : g_bad_af
    $error("soft_fifo_ctrl: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH != clamp_thresh(AE_THRESH, 0, DEPTH - 1)) begin : g_bad_ae
    $error("soft_fifo_ctrl: AE_THRESH must lie in 0..DEPTH-1");
  end
  if (LOG_DEPTH != clamp_thresh(LOG_DEPTH, LOG_DEPTH_MIN, LOG_DEPTH_MAX)) begin : g_bad_depth
    $error("soft_fifo_ctrl: LOG_DEPTH must lie in 1..12");
  end

  logic       rd_acc;
  err_flags_t err_q;

  // Accepts are judged on the current state only: no write-through-full, no read bypass.
  always_comb begin
    wr_acc = wrreq & ~full;
    rd_acc = rdreq & ~empty;
  end

  // Status flags are pure decodes of the registered occupancy.
  always_comb begin
    full         = (usedw == DEPTH_U);
    empty        = (usedw == '0);
    almost_full  = (usedw >= AF_U);
    almost_empty = (usedw <= AE_U);
    overflow     = err_q.overflow;
    underflow    = err_q.underflow;
  end

  // Pointers advance on their own accepts and wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy moves only when exactly one side is accepted.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      usedw <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   usedw <= usedw + CNT_ONE;
        2'b01:   usedw <= usedw - CNT_ONE;
        default: usedw <= usedw;
      endcase
    end
  end

  // Sticky errors: a new violation beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_q <= '0;
    end else begin
      if (wrreq && full)   err_q.overflow  <= 1'b1;
      else if (err_clr)    err_q.overflow  <= 1'b0;
      if (rdreq && empty)  err_q.underflow <= 1'b1;
      else if (err_clr)    err_q.underflow <= 1'b0;
    end
  end

endmodule

// File: rtl/soft_fifo_flags.sv
// Register-based FIFO with occupancy, almost-full/empty thresholds and sticky error flags.
// Latency: show-ahead q valid whenever non-empty; registered q valid one cycle after an accepted read.
// Backpressure: full/almost_full advise the writer; writes while full and reads while empty are dropped.
module soft_fifo_flags
  import soft_fifo_pkg::*;
#(
  parameter int WIDTH      = 512,
  parameter int LOG_DEPTH  = 9,
  parameter int SHOW_AHEAD = 1,
  parameter int AF_THRESH  = (1 << LOG_DEPTH) - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wrreq,
  input  logic [WIDTH-1:0]     data,
  input  logic                 rdreq,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     q,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [LOG_DEPTH:0]   usedw,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic                 wr_acc;
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [WIDTH-1:0]     mem [DEPTH];

  soft_fifo_ctrl #(
    .LOG_DEPTH (LOG_DEPTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ctrl (
    .clock        (clock),
    .reset_n      (reset_n),
    .wrreq        (wrreq),
    .rdreq        (rdreq),
    .err_clr      (err_clr),
    .wr_acc       (wr_acc),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .usedw        (usedw),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Storage is deliberately not reset; occupancy alone defines what is valid.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= data;
  end

  if (SHOW_AHEAD != 0) begin : g_show_ahead
    // Head word is presented combinationally; meaningless while empty.
    always_comb q = mem[rd_ptr];
  end else begin : g_registered
    logic rd_acc;
    logic [WIDTH-1:0] q_reg;

    // Same accept rule as the controller, local so the registered path owns its enable.
    always_comb rd_acc = rdreq & ~empty;

    // Capture the head on an accepted read and hold it otherwise.
    always_ff @(posedge clock) begin
      if (!reset_n)    q_reg <= '0;
      else if (rd_acc) q_reg <= mem[rd_ptr];
    end

    // Drive the output from the capture register.
    always_comb q = q_reg;
  end

endmodule

// File: tb/tb_soft_fifo_flags.sv
// Bench: show-ahead and registered instances share stimulus and are checked against a queue model.
module tb_soft_fifo_flags;

  localparam int W  = 8;
  localparam int LD = 2;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         wrreq;
  logic [W-1:0] data;
  logic         rdreq;
  logic         err_clr;

  logic [W-1:0] q_sa, q_rg;
  logic         full_sa, empty_sa, af_sa, ae_sa, ovf_sa, unf_sa;
  logic         full_rg, empty_rg, af_rg, ae_rg, ovf_rg, unf_rg;
  logic [LD:0]  usedw_sa, usedw_rg;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] mq[$];
  bit           m_ov, m_un;
  logic [W-1:0] m_qreg;

  always #5 clock = ~clock;

  soft_fifo_flags #(.WIDTH(W), .LOG_DEPTH(LD), .SHOW_AHEAD(1), .AF_THRESH(AF), .AE_THRESH(AE)) dut_sa (
    .clock(clock), .reset_n(reset_n), .wrreq(wrreq), .data(data), .rdreq(rdreq), .err_clr(err_clr),
    .q(q_sa), .full(full_sa), .empty(empty_sa), .almost_full(af_sa), .almost_empty(ae_sa),
    .usedw(usedw_sa), .overflow(ovf_sa), .underflow(unf_sa)
  );

  soft_fifo_flags #(.WIDTH(W), .LOG_DEPTH(LD), .SHOW_AHEAD(0), .AF_THRESH(AF), .AE_THRESH(AE)) dut_rg (
    .clock(clock), .reset_n(reset_n), .wrreq(wrreq), .data(data), .rdreq(rdreq), .err_clr(err_clr),
    .q(q_rg), .full(full_rg), .empty(empty_rg), .almost_full(af_rg), .almost_empty(ae_rg),
    .usedw(usedw_rg), .overflow(ovf_rg), .underflow(unf_rg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a queue plus two sticky bits and the last value read.
  task automatic model_update(input bit wr, input logic [W-1:0] d, input bit rd, input bit clr, input bit rst);
    bit was_full, was_empty;
    if (rst) begin
      mq.delete();
      m_ov   = 0;
      m_un   = 0;
      m_qreg = '0;
    end else begin
      was_full  = (mq.size() == D);
      was_empty = (mq.size() == 0);
      if (rd && !was_empty) m_qreg = mq.pop_front();
      if (wr && !was_full)  mq.push_back(d);
      if (wr && was_full)   m_ov = 1;
      else if (clr)         m_ov = 0;
      if (rd && was_empty)  m_un = 1;
      else if (clr)         m_un = 0;
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("usedw_sa", 32'(usedw_sa), 32'(n));
    chk("usedw_rg", 32'(usedw_rg), 32'(n));
    chk("full_sa",  32'(full_sa),  32'(n == D));
    chk("full_rg",  32'(full_rg),  32'(n == D));
    chk("empty_sa", 32'(empty_sa), 32'(n == 0));
    chk("empty_rg", 32'(empty_rg), 32'(n == 0));
    chk("af_sa",    32'(af_sa),    32'(n >= AF));
    chk("af_rg",    32'(af_rg),    32'(n >= AF));
    chk("ae_sa",    32'(ae_sa),    32'(n <= AE));
    chk("ae_rg",    32'(ae_rg),    32'(n <= AE));
    chk("ovf_sa",   32'(ovf_sa),   32'(m_ov));
    chk("ovf_rg",   32'(ovf_rg),   32'(m_ov));
    chk("unf_sa",   32'(unf_sa),   32'(m_un));
    chk("unf_rg",   32'(unf_rg),   32'(m_un));
    if (n != 0) chk("q_sa_head", 32'(q_sa), 32'(mq[0]));
    chk("q_rg", 32'(q_rg), 32'(m_qreg));
  endtask

  // Drive one cycle, advance the model at the edge, compare on the falling edge.
  task automatic step(input bit wr, input logic [W-1:0] d, input bit rd, input bit clr, input bit rst);
    wrreq   = wr;
    data    = d;
    rdreq   = rd;
    err_clr = clr;
    reset_n = ~rst;
    @(posedge clock);
    model_update(wr, d, rd, clr, rst);
    @(negedge clock);
    check_model();
  endtask

  initial begin
    logic [W-1:0] exp_rd [4];
    exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h44;
    wrreq = 0; data = '0; rdreq = 0; err_clr = 0; reset_n = 0;

    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    chk("rst_usedw", 32'(usedw_sa), 32'd0);
    chk("rst_empty", 32'(empty_sa), 32'd1);
    chk("rst_ae",    32'(ae_rg),    32'd1);
    chk("rst_q_rg",  32'(q_rg),     32'd0);

    // Fill to full, then overflow.
    step(1, 8'h11, 0, 0, 0);
    chk("fill_usedw1", 32'(usedw_sa), 32'd1);
    chk("fill_ae1",    32'(ae_sa),    32'd1);
    step(1, 8'h22, 0, 0, 0);
    chk("fill_usedw2", 32'(usedw_sa), 32'd2);
    chk("fill_ae2",    32'(ae_sa),    32'd0);
    chk("fill_af2",    32'(af_sa),    32'd0);
    step(1, 8'h33, 0, 0, 0);
    chk("fill_af3",    32'(af_sa),    32'd1);
    step(1, 8'h44, 0, 0, 0);
    chk("fill_full4",  32'(full_rg),  32'd1);
    step(1, 8'h55, 0, 0, 0);
    chk("ovf_set",     32'(ovf_sa),   32'd1);
    chk("ovf_usedw",   32'(usedw_rg), 32'd4);

    // Drain in order, then underflow.
    for (int i = 0; i < 4; i++) begin
      chk("drain_sa_head", 32'(q_sa), 32'(exp_rd[i]));
      step(0, 8'h00, 1, 0, 0);
      chk("drain_rg_q", 32'(q_rg), 32'(exp_rd[i]));
    end
    chk("drain_empty", 32'(empty_sa), 32'd1);
    step(0, 8'h00, 1, 0, 0);
    chk("unf_set",   32'(unf_rg),   32'd1);
    chk("unf_usedw", 32'(usedw_rg), 32'd0);
    step(0, 8'h00, 0, 1, 0);
    chk("clr_ovf", 32'(ovf_sa), 32'd0);

    // Registered read latency and hold.
    step(1, 8'hA5, 0, 0, 0);
    chk("rg_hold_old", 32'(q_rg), 32'h44);
    step(0, 8'h00, 1, 0, 0);
    chk("rg_a5", 32'(q_rg), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 0, 0, 0);
      chk("rg_a5_hold", 32'(q_rg), 32'hA5);
    end

    // Steady-state simultaneous read/write across pointer wrap.
    step(1, 8'h80, 0, 0, 0);
    step(1, 8'h81, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'h82 + i), 1, 0, 0);
      chk("rw_usedw", 32'(usedw_sa), 32'd2);
      chk("rw_order", 32'(q_rg), 32'(8'h80 + i));
      chk("rw_unf",   32'(unf_sa),   32'd0);
    end

    // Simultaneous read/write on empty: no bypass.
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'h77, 1, 0, 0);
    chk("nobyp_usedw", 32'(usedw_sa), 32'd1);
    chk("nobyp_unf",   32'(unf_sa),   32'd1);
    step(0, 8'h00, 0, 1, 0);
    chk("clr_unf", 32'(unf_rg), 32'd0);
    step(0, 8'h00, 1, 0, 0);
    chk("nobyp_data", 32'(q_rg), 32'h77);
    step(0, 8'h00, 1, 1, 0);
    chk("set_beats_clr", 32'(unf_sa), 32'd1);

    // Mid-operation reset discards contents and the concurrent write.
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(1, 8'h03, 0, 0, 1);
    chk("mrst_usedw", 32'(usedw_rg), 32'd0);
    chk("mrst_empty", 32'(empty_rg), 32'd1);
    chk("mrst_unf",   32'(unf_rg),   32'd0);
    step(0, 8'h00, 0, 0, 0);
    chk("mrst_discard", 32'(usedw_sa), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
